// File: rtl/enc_pkg.sv
// Shared definitions for the instruction encoder: kinds, opcodes, functs, field layout.
// Jump kinds (JR, J, JAL) are only legal when ENC_JUMP_EN is defined.
package enc_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned KIND_W = 4;
    localparam int unsigned OP_W   = 6;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned IMM_W  = 16;
    localparam int unsigned TGT_W  = 26;

    localparam int unsigned OP_LSB = 26;
    localparam int unsigned RS_LSB = 21;
    localparam int unsigned RT_LSB = 16;
    localparam int unsigned RD_LSB = 11;
    localparam int unsigned SH_LSB = 6;

    typedef enum logic [KIND_W-1:0] {
        K_ADD  = 4'd0,
        K_SUB  = 4'd1,
        K_AND  = 4'd2,
        K_OR   = 4'd3,
        K_SLT  = 4'd4,
        K_JR   = 4'd5,
        K_SLL  = 4'd6,
        K_ADDI = 4'd7,
        K_ORI  = 4'd8,
        K_LW   = 4'd9,
        K_SW   = 4'd10,
        K_BEQ  = 4'd11,
        K_J    = 4'd12,
        K_JAL  = 4'd13
    } kind_e;

    typedef enum logic {S_IDLE, S_HOLD} state_e;

    localparam logic [OP_W-1:0] FN_ADD = 6'd32;
    localparam logic [OP_W-1:0] FN_SUB = 6'd34;
    localparam logic [OP_W-1:0] FN_AND = 6'd36;
    localparam logic [OP_W-1:0] FN_OR  = 6'd37;
    localparam logic [OP_W-1:0] FN_SLT = 6'd42;
    localparam logic [OP_W-1:0] FN_JR  = 6'd8;
    localparam logic [OP_W-1:0] FN_SLL = 6'd0;

    localparam logic [OP_W-1:0] OPC_ADDI = 6'd8;
    localparam logic [OP_W-1:0] OPC_ORI  = 6'd13;
    localparam logic [OP_W-1:0] OPC_LW   = 6'd35;
    localparam logic [OP_W-1:0] OPC_SW   = 6'd43;
    localparam logic [OP_W-1:0] OPC_BEQ  = 6'd4;
    localparam logic [OP_W-1:0] OPC_J    = 6'd2;
    localparam logic [OP_W-1:0] OPC_JAL  = 6'd3;

    function automatic logic [WORD_W-1:0] r_word(logic [REG_W-1:0] rs, logic [REG_W-1:0] rt,
                                                 logic [REG_W-1:0] rd, logic [REG_W-1:0] sh,
                                                 logic [OP_W-1:0] funct);
        return (WORD_W'(rs) << RS_LSB) | (WORD_W'(rt) << RT_LSB) | (WORD_W'(rd) << RD_LSB)
             | (WORD_W'(sh) << SH_LSB) | WORD_W'(funct);
    endfunction

    function automatic logic [WORD_W-1:0] i_word(logic [OP_W-1:0] op, logic [REG_W-1:0] rs,
                                                 logic [REG_W-1:0] rt, logic [IMM_W-1:0] imm);
        return (WORD_W'(op) << OP_LSB) | (WORD_W'(rs) << RS_LSB) | (WORD_W'(rt) << RT_LSB)
             | WORD_W'(imm);
    endfunction

    function automatic logic [WORD_W-1:0] j_word(logic [OP_W-1:0] op, logic [TGT_W-1:0] target);
        return (WORD_W'(op) << OP_LSB) | WORD_W'(target);
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational map from request kind and fields to a 32-bit word plus an illegal flag.
// ENC_JUMP_EN enables JR, J and JAL; without it those kinds report illegal.
module instr_pack
    import enc_pkg::*;
(
    input  logic [KIND_W-1:0] kind,
    input  logic [REG_W-1:0]  rs,
    input  logic [REG_W-1:0]  rt,
    input  logic [REG_W-1:0]  rd,
    input  logic [REG_W-1:0]  shamt,
    input  logic [IMM_W-1:0]  imm,
    input  logic [TGT_W-1:0]  target,
    output logic [WORD_W-1:0] word,
    output logic              illegal
);

    // shamt is only meaningful for SLL; SLL has no rs; JR carries only rs
    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (kind)
            K_ADD:  word = r_word(rs, rt, rd, '0, FN_ADD);
            K_SUB:  word = r_word(rs, rt, rd, '0, FN_SUB);
            K_AND:  word = r_word(rs, rt, rd, '0, FN_AND);
            K_OR:   word = r_word(rs, rt, rd, '0, FN_OR);
            K_SLT:  word = r_word(rs, rt, rd, '0, FN_SLT);
            K_SLL:  word = r_word('0, rt, rd, shamt, FN_SLL);
            K_ADDI: word = i_word(OPC_ADDI, rs, rt, imm);
            K_ORI:  word = i_word(OPC_ORI, rs, rt, imm);
            K_LW:   word = i_word(OPC_LW, rs, rt, imm);
            K_SW:   word = i_word(OPC_SW, rs, rt, imm);
            K_BEQ:  word = i_word(OPC_BEQ, rs, rt, imm);
`ifdef ENC_JUMP_EN
            K_JR:   word = r_word(rs, '0, '0, '0, FN_JR);
            K_J:    word = j_word(OPC_J, target);
            K_JAL:  word = j_word(OPC_JAL, target);
`endif
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Encodes instruction requests into words and streams them into instruction memory.
// Single-entry output register with ready/valid handshake; ENC_JUMP_EN enables jump kinds.
module instr_encoder
    import enc_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_kind,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    input  logic              restart,
    output logic              imem_we,
    input  logic              imem_ready,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              err_illegal,
    output logic [15:0]       words_written
);

    logic [WORD_W-1:0] word;
    logic              illegal;
    logic              accept;
    logic              write;
    logic              load;
    logic              restart_pend;
    state_e            state;

    instr_pack u_pack (
        .kind    (req_kind),
        .rs      (rs),
        .rt      (rt),
        .rd      (rd),
        .shamt   (shamt),
        .imm     (imm),
        .target  (target),
        .word    (word),
        .illegal (illegal)
    );

    assign req_ready = !imem_we || imem_ready;
    assign accept    = req_valid && req_ready;
    assign write     = imem_we && imem_ready;
    assign load      = accept && !illegal;

    // A restart seen while a word is stalled is deferred so the held address stays stable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            imem_we       <= 1'b0;
            imem_addr     <= '0;
            imem_wdata    <= '0;
            err_illegal   <= 1'b0;
            words_written <= '0;
            restart_pend  <= 1'b0;
        end else begin
            if (accept && illegal) begin
                err_illegal <= 1'b1;
            end
            if (write && words_written != 16'hFFFF) begin
                words_written <= words_written + 16'd1;
            end

            if (write) begin
                imem_addr    <= (restart || restart_pend) ? '0 : imem_addr + ADDR_W'(4);
                restart_pend <= 1'b0;
            end else if (restart) begin
                if (imem_we) begin
                    restart_pend <= 1'b1;
                end else begin
                    imem_addr <= '0;
                end
            end

            case (state)
                S_IDLE: begin
                    if (load) begin
                        state      <= S_HOLD;
                        imem_we    <= 1'b1;
                        imem_wdata <= word;
                    end
                end
                S_HOLD: begin
                    if (write) begin
                        if (load) begin
                            imem_wdata <= word;
                        end else begin
                            state   <= S_IDLE;
                            imem_we <= 1'b0;
                        end
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    imem_we <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, meaning the width of the byte-address counter for instruction memory.
REQ-002 The block SHALL have the port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-003 The block SHALL have the port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have the ports req_valid (input, 1 bit) and req_ready (output, 1 bit): the encode-request handshake.
REQ-005 The block SHALL have the port req_kind, input, 4 bits: the instruction kind: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 JR, 6 SLL, 7 ADDI, 8 ORI, 9 LW, 10 SW, 11 BEQ, 12 J, 13 JAL; 14 and 15 are illegal.
REQ-006 The block SHALL have the ports rs, rt, rd and shamt, each input, 5 bits: the register and shift fields.
REQ-007 The block SHALL have the ports imm (input, 16 bits) and target (input, 26 bits): the immediate and jump-target fields.
REQ-008 The block SHALL have the port restart, input, 1 bit: a synchronous pulse that sets the write address to 0.
REQ-009 The block SHALL have the ports imem_we (output, 1 bit), imem_ready (input, 1 bit), imem_addr (output, ADDR_W bits) and imem_wdata (output, 32 bits): the instruction-memory write port.
REQ-010 The block SHALL have the ports err_illegal (output, 1 bit, sticky) and words_written (output, 16 bits).

Function
REQ-011 The encoding SHALL be: R-type = op 0 | rs | rt | rd | shamt | funct; I-type = op | rs | rt | imm; J-type = op | target.
REQ-012 The funct values SHALL be: ADD 32, SUB 34, AND 36, OR 37, SLT 42, JR 8, SLL 0.
REQ-013 The opcode values SHALL be: ADDI 8, ORI 13, LW 35, SW 43, BEQ 4, J 2, JAL 3.
REQ-014 The field forcing SHALL be: shamt forced to 0 for every kind except SLL; rs forced to 0 for SLL; rt, rd and shamt forced to 0 for JR.
REQ-015 The block SHALL hold a single-entry output register; req_ready SHALL equal !imem_we || imem_ready.
REQ-016 A request SHALL be accepted when req_valid && req_ready; imem_we and imem_wdata SHALL be valid on the next cycle, giving a latency of 1 cycle.
REQ-017 While imem_we && !imem_ready, imem_we, imem_addr and imem_wdata SHALL be held stable.
REQ-018 On each write (imem_we && imem_ready): imem_addr SHALL advance by 4, wrapping modulo 2^ADDR_W, and words_written SHALL increment, saturating at 0xFFFF.
REQ-019 A write completing in the same cycle as a new acceptance SHALL load the new word back-to-back with no bubble.
REQ-020 An illegal kind SHALL be accepted, SHALL NOT produce a write, and SHALL set err_illegal, which is cleared only by reset.
REQ-021 The state machine SHALL have states IDLE (no entry held) and HOLD (entry held), with transitions IDLE->HOLD on accept, HOLD->IDLE on a write with no accept, and HOLD->HOLD on write+accept or stall.
REQ-022 restart SHALL set the address to 0 for the next write; restart coincident with a write SHALL take priority, making the address 0 rather than +4.
REQ-023 restart SHALL NOT discard a held entry.
REQ-024 imem_addr bits [1:0] SHALL always be 0.

Reset
REQ-025 When rst_n is low, the block SHALL asynchronously drive: imem_we=0, imem_addr=0, imem_wdata=0, err_illegal=0, words_written=0, state IDLE.
REQ-026 After reset, req_ready SHALL be 1.
REQ-027 Reset asserted mid-stall SHALL drop the held word.

Configuration
REQ-028 With the macro ENC_JUMP_EN defined, J, JAL and JR SHALL be encoded per REQ-011..REQ-014.
REQ-029 Without ENC_JUMP_EN, kinds 5, 12 and 13 SHALL be treated as illegal per REQ-020.

Structure
REQ-030 A shared package enc_pkg SHALL hold the kind enumeration, the opcode and funct constants, and the field bit positions.
REQ-031 A combinational sub-module instr_pack SHALL map kind and fields to {word, illegal}; instr_encoder SHALL own the handshake, state, address and counters.

Verification
REQ-032 The bench SHALL check: ADD rs=1 rt=2 rd=3 shamt=9 -> imem_wdata=0x00221820 at addr 0, one cycle after accept.
REQ-033 The bench SHALL check: SLL rs=7 rt=3 rd=2 shamt=4 -> 0x00031100; then ADDI rs=0 rt=8 imm=5 -> 0x20080005 at addr 4, back-to-back.
REQ-034 The bench SHALL check: LW rs=29 rt=9 imm=4 with imem_ready low for 3 cycles -> 0x8FA90004 held stable, req_ready=0, addr unchanged until accepted.
REQ-035 The bench SHALL check: J target=0x40 then JAL target=0x10 -> 0x08000040 and 0x0C000010 with ENC_JUMP_EN defined; without it, no writes occur and err_illegal=1.
REQ-036 The bench SHALL check: kind 15 -> no write and err_illegal=1; a subsequent legal request is still written.
REQ-037 The bench SHALL check: ADDR_W=4 with 5 writes -> addresses 0, 4, 8, 12, 0; and restart asserted with a write -> next addr 0.
